// File: rtl/test.sv
// Parameterised 2-read / 1-write register bank with combinational reads and async active-high clear.
// Define WR_BYPASS_EN to forward the in-flight write data to a read port addressing the written register.
module test #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_reg,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] r_reg1,
  input  logic [ADDR_W-1:0] r_reg2,
  output logic [DATA_W-1:0] r_data1,
  output logic [DATA_W-1:0] r_data2
);

  localparam int unsigned NUM_REGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Storage: whole bank clears while rst is high; one register loads per write edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wr_reg] <= wr_data;
    end
  end

  // Read ports
  always_comb begin
    r_data1 = regs[r_reg1];
    r_data2 = regs[r_reg2];
`ifdef WR_BYPASS_EN
    if (wr_en && !rst && (r_reg1 == wr_reg)) r_data1 = wr_data;
    if (wr_en && !rst && (r_reg2 == wr_reg)) r_data2 = wr_data;
`endif
  end

endmodule

// File: tb/tb_test.sv
// Bench for the register bank: directed literal checks plus randomized traffic against an array model.
module tb_test;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_reg;
  logic [15:0] wr_data;
  logic [2:0]  r_reg1;
  logic [2:0]  r_reg2;
  logic [15:0] r_data1;
  logic [15:0] r_data2;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 0;

  logic [15:0] mdl [8];

  test #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
    .r_reg1(r_reg1), .r_reg2(r_reg2), .r_data1(r_data1), .r_data2(r_data2)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] exp_rd(input logic [2:0] a);
    if (rst) return 16'h0000;
`ifdef WR_BYPASS_EN
    if (wr_en && a == wr_reg) return wr_data;
`endif
    return mdl[a];
  endfunction

  task automatic clear_mdl();
    for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
  endtask

  // Advance one clock; the model commits what the bank should have stored at that edge
  task automatic step();
    @(posedge clk);
    if (!rst && wr_en) mdl[wr_reg] = wr_data;
    #1;
  endtask

  // Continuous compare against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("rd1_model", r_data1, exp_rd(r_reg1));
      chk("rd2_model", r_data2, exp_rd(r_reg2));
    end
  end

  initial begin
    logic [15:0] lit [8];
    lit[0] = 16'h0004; lit[1] = 16'h0008; lit[2] = 16'h000c; lit[3] = 16'h0010;
    lit[4] = 16'h0014; lit[5] = 16'h0018; lit[6] = 16'h001c; lit[7] = 16'h0020;

    rst = 1; wr_en = 0; wr_reg = 0; wr_data = 0; r_reg1 = 0; r_reg2 = 0;
    clear_mdl();
    #1;
    chk_en = 1;

    // Reset sweep, including a write attempt that must be ignored
    for (int i = 0; i < 8; i++) begin
      r_reg1 = 3'(i); r_reg2 = 3'(7 - i);
      wr_en = (i == 3); wr_reg = 3'(i); wr_data = 16'hdead;
      #1;
      chk("rst_rd1", r_data1, 16'h0000);
      chk("rst_rd2", r_data2, 16'h0000);
      step();
    end
    wr_en = 0;
    step();
    rst = 0;
    step();

    // Write sweep with same-address read-back after each edge
    for (int i = 0; i < 8; i++) begin
      wr_en = 1; wr_reg = 3'(i); wr_data = 16'((i + 1) * 4);
      r_reg1 = 3'(i); r_reg2 = 3'(i);
      step();
      chk("sweep_rd1", r_data1, lit[i]);
      chk("sweep_rd2", r_data2, lit[i]);
    end

    // Writes disabled: stored values must hold
    wr_en = 0; wr_data = 16'hffff;
    repeat (4) step();
    for (int i = 0; i < 8; i++) begin
      r_reg1 = 3'(i); r_reg2 = 3'(i);
      #1;
      chk("hold_rd1", r_data1, lit[i]);
      chk("hold_rd2", r_data2, lit[i]);
    end

    // Independent read ports
    r_reg1 = 3'd2; r_reg2 = 3'd7; #1;
    chk("dual_rd1", r_data1, 16'h000c);
    chk("dual_rd2", r_data2, 16'h0020);
    r_reg1 = 3'd7; r_reg2 = 3'd2; #1;
    chk("swap_rd1", r_data1, 16'h0020);
    chk("swap_rd2", r_data2, 16'h000c);
    step();

    // Read of the register being written, before and after the edge
    wr_en = 1; wr_reg = 3'd5; wr_data = 16'h1234; r_reg1 = 3'd5; r_reg2 = 3'd0;
    #1;
`ifdef WR_BYPASS_EN
    chk("pre_edge_rd1", r_data1, 16'h1234);
`else
    chk("pre_edge_rd1", r_data1, 16'h0018);
`endif
    chk("pre_edge_rd2", r_data2, 16'h0004);
    step();
    chk("post_edge_rd1", r_data1, 16'h1234);

    // Reset asserted mid-cycle discards the pending write
    wr_en = 1; wr_reg = 3'd3; wr_data = 16'habcd; r_reg1 = 3'd3;
    #2;
    rst = 1; clear_mdl();
    #1;
    for (int i = 0; i < 8; i++) begin
      r_reg2 = 3'(i); #1;
      chk("midrst_rd2", r_data2, 16'h0000);
    end
    step();
    #1; rst = 0; wr_en = 0;
    #1;
    chk("midrst_reg3", r_data1, 16'h0000);
    step();

    // Randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_reg  = 3'($urandom_range(0, 7));
      wr_data = 16'($urandom);
      r_reg1  = ($urandom_range(0, 3) == 0) ? wr_reg : 3'($urandom_range(0, 7));
      r_reg2  = ($urandom_range(0, 3) == 0) ? r_reg1 : 3'($urandom_range(0, 7));
      if ($urandom_range(0, 29) == 0) begin
        rst = 1; clear_mdl();
      end else begin
        rst = 0;
      end
      step();
    end

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
